// File: rtl/md5_hasher_pkg.sv
// Shared types and constants for the md5 string-match command/result path.
// The result-register logic decodes beats with the same beat_t encodings.
package md5_hasher_pkg;

    localparam int MAX_STR_BYTES = 55;
    localparam int CNT_W         = 32;
    localparam int NCH_W         = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_GAP,
        S_FEED,
        S_WAIT_DONE,
        S_HDR0,
        S_HDR1,
        S_READ,
        S_EMIT
    } state_t;

    typedef enum logic [1:0] {
        BEAT_HDR0 = 2'd0,
        BEAT_HDR1 = 2'd1,
        BEAT_DATA = 2'd2,
        BEAT_NONE = 2'd3
    } beat_t;

    // str_len is in bits; round up to whole chars, capped at the single-block limit.
    function automatic logic [NCH_W-1:0] calc_nchars(input logic [15:0] str_len,
                                                     input int max_chars);
        logic [16:0] w_bytes;
        w_bytes = ({1'b0, str_len} + 17'd7) >> 3;
        if (int'(w_bytes) > max_chars) return NCH_W'(max_chars);
        return w_bytes[NCH_W-1:0];
    endfunction

endpackage

// File: rtl/word_to_byte_unpacker.sv
// Unpacks 32-bit little-endian-lane words into one byte per cycle, stopping
// after a loaded byte count; surplus bytes of the final word are dropped.
module word_to_byte_unpacker #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_enable,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [7:0]       o_byte,
    output logic             o_byte_valid,
    output logic             o_last
);

    logic [31:0]      r_buf;
    logic [1:0]       r_lane;
    logic             r_full;
    logic [CNT_W-1:0] r_rem;
    logic             w_accept;

    // A word is only taken once the previous one has fully drained.
    assign s_ready      = i_enable && !r_full && (r_rem != '0);
    assign w_accept     = s_valid && s_ready;
    assign o_byte_valid = r_full;
    assign o_byte       = r_full ? r_buf[{r_lane, 3'b000} +: 8] : 8'd0;
    assign o_last       = r_full && (r_rem == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf  <= '0;
            r_lane <= '0;
            r_full <= 1'b0;
            r_rem  <= '0;
        end else if (i_load) begin
            r_rem  <= i_count;
            r_lane <= '0;
            r_full <= 1'b0;
        end else if (r_full) begin
            r_rem  <= r_rem - CNT_W'(1);
            r_lane <= r_lane + 2'd1;
            if (r_lane == 2'd3 || o_last) r_full <= 1'b0;
        end else if (w_accept) begin
            r_buf  <= s_data;
            r_lane <= '0;
            r_full <= 1'b1;
        end
    end

endmodule

// File: rtl/proc_stream_driver.sv
// Command-side driver: feeds the match datapath byte-serially, then returns
// match header beats and the packed matched string on a valid/ready stream.
module proc_stream_driver #(
    parameter int MAX_STR_BYTES = md5_hasher_pkg::MAX_STR_BYTES,
    parameter int CNT_W         = md5_hasher_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [CNT_W-1:0]      cmd_num_bytes,
    input  logic [15:0]           cmd_str_len,
    input  logic [127:0]          cmd_target_hash,
    input  logic [31:0]           s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  proc_start,
    output logic [CNT_W-1:0]      proc_num_bytes,
    output logic [127:0]          proc_target_hash,
    output logic [15:0]           proc_str_len,
    output logic [7:0]            proc_data,
    output logic                  proc_data_valid,
    output logic                  proc_match_char_next,
    input  logic                  proc_done,
    input  logic                  proc_match,
    input  logic [CNT_W-1:0]      proc_byte_pos,
    input  logic [7:0]            proc_match_char,
    output logic [31:0]           res_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_last,
    output logic                  busy,
    output md5_hasher_pkg::state_t o_dbg_state
);

    import md5_hasher_pkg::*;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_num_bytes;
    logic [127:0]     r_hash;
    logic [15:0]      r_str_len;
    logic [NCH_W-1:0] r_nchars;
    logic             r_match;
    logic [CNT_W-1:0] r_pos;
    logic [31:0]      r_pack;
    logic [NCH_W-1:0] r_idx;

    logic             w_cmd_fire;
    logic             w_byte_last;
    logic             w_hdr_last;
    logic             w_emit_last;
    logic             w_read_done;
    beat_t            w_beat;

    assign w_cmd_fire  = cmd_valid && (r_state == S_IDLE);
    assign w_hdr_last  = !r_match || (r_nchars == '0);
    assign w_emit_last = (r_idx == r_nchars);
    // A pack word closes on its fourth lane or on the final char of the string.
    assign w_read_done = (r_idx[1:0] == 2'd3) || ((r_idx + NCH_W'(1)) == r_nchars);

    word_to_byte_unpacker #(.CNT_W(CNT_W)) u_unpacker (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_cmd_fire),
        .i_count      (cmd_num_bytes),
        .i_enable     (r_state == S_FEED),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .o_byte       (proc_data),
        .o_byte_valid (proc_data_valid),
        .o_last       (w_byte_last)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (cmd_valid) w_next = S_START;
            S_START:     w_next = S_GAP;
            // proc_done may still reflect the previous command here, so it is not looked at.
            S_GAP:       w_next = (r_num_bytes == '0) ? S_WAIT_DONE : S_FEED;
            S_FEED:      if (proc_data_valid && w_byte_last) w_next = S_WAIT_DONE;
            S_WAIT_DONE: if (proc_done) w_next = S_HDR0;
            S_HDR0:      if (res_ready) w_next = S_HDR1;
            S_HDR1:      if (res_ready) w_next = (r_match && r_nchars != '0) ? S_READ : S_IDLE;
            S_READ:      if (w_read_done) w_next = S_EMIT;
            S_EMIT:      if (res_ready) w_next = w_emit_last ? S_IDLE : S_READ;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready            = (r_state == S_IDLE);
        busy                 = (r_state != S_IDLE);
        proc_start           = (r_state == S_START);
        proc_match_char_next = (r_state == S_READ);
        w_beat               = BEAT_NONE;
        res_valid            = 1'b0;
        res_last             = 1'b0;
        res_data             = 32'd0;
        case (r_state)
            S_HDR0:  w_beat = BEAT_HDR0;
            S_HDR1:  w_beat = BEAT_HDR1;
            S_EMIT:  w_beat = BEAT_DATA;
            default: w_beat = BEAT_NONE;
        endcase
        case (w_beat)
            BEAT_HDR0: begin
                res_valid = 1'b1;
                res_last  = w_hdr_last;
                res_data  = {31'd0, r_match};
            end
            BEAT_HDR1: begin
                res_valid = 1'b1;
                res_last  = w_hdr_last;
                res_data  = r_pos[31:0];
            end
            BEAT_DATA: begin
                res_valid = 1'b1;
                res_last  = w_emit_last;
                res_data  = r_pack;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_num_bytes <= '0;
            r_hash      <= '0;
            r_str_len   <= '0;
            r_nchars    <= '0;
            r_match     <= 1'b0;
            r_pos       <= '0;
            r_pack      <= '0;
            r_idx       <= '0;
        end else begin
            if (w_cmd_fire) begin
                r_num_bytes <= cmd_num_bytes;
                r_hash      <= cmd_target_hash;
                r_str_len   <= cmd_str_len;
                r_nchars    <= calc_nchars(cmd_str_len, MAX_STR_BYTES);
            end
            // Header fields are frozen at completion so beats stay stable under backpressure.
            if (r_state == S_WAIT_DONE && proc_done) begin
                r_match <= proc_match;
                r_pos   <= proc_byte_pos;
            end
            if (r_state == S_HDR1 && res_ready) begin
                r_pack <= '0;
                r_idx  <= '0;
            end
            if (r_state == S_READ) begin
                r_pack[{r_idx[1:0], 3'b000} +: 8] <= proc_match_char;
                r_idx <= r_idx + NCH_W'(1);
            end
            if (r_state == S_EMIT && res_ready) r_pack <= '0;
        end
    end

    assign proc_num_bytes   = r_num_bytes;
    assign proc_target_hash = r_hash;
    assign proc_str_len     = r_str_len;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_proc_stream_driver.sv
// Directed bench for proc_stream_driver with a small datapath model and
// expected-queue scoreboards for the byte stream and the result beats.
module tb_proc_stream_driver;

    import md5_hasher_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [31:0]  cmd_num_bytes;
    logic [15:0]  cmd_str_len;
    logic [127:0] cmd_target_hash;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_ready;
    logic         proc_start;
    logic [31:0]  proc_num_bytes;
    logic [127:0] proc_target_hash;
    logic [15:0]  proc_str_len;
    logic [7:0]   proc_data;
    logic         proc_data_valid;
    logic         proc_match_char_next;
    logic         proc_done;
    logic         proc_match;
    logic [31:0]  proc_byte_pos;
    logic [7:0]   proc_match_char;
    logic [31:0]  res_data;
    logic         res_valid;
    logic         res_ready;
    logic         res_last;
    logic         busy;
    state_t       dbg_state;

    proc_stream_driver dut (
        .clk                  (clk),
        .reset                (reset),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_num_bytes        (cmd_num_bytes),
        .cmd_str_len          (cmd_str_len),
        .cmd_target_hash      (cmd_target_hash),
        .s_data               (s_data),
        .s_valid              (s_valid),
        .s_ready              (s_ready),
        .proc_start           (proc_start),
        .proc_num_bytes       (proc_num_bytes),
        .proc_target_hash     (proc_target_hash),
        .proc_str_len         (proc_str_len),
        .proc_data            (proc_data),
        .proc_data_valid      (proc_data_valid),
        .proc_match_char_next (proc_match_char_next),
        .proc_done            (proc_done),
        .proc_match           (proc_match),
        .proc_byte_pos        (proc_byte_pos),
        .proc_match_char      (proc_match_char),
        .res_data             (res_data),
        .res_valid            (res_valid),
        .res_ready            (res_ready),
        .res_last             (res_last),
        .busy                 (busy),
        .o_dbg_state          (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  exp_byte_q[$];
    logic [32:0] exp_res_q[$];
    logic [31:0] word_q[$];
    int          n_strobes = 0;
    int          n_start = 0;
    int          n_char_next = 0;
    int          n_words = 0;
    logic        hs_word = 1'b0;
    logic        hs_char = 1'b0;
    logic [7:0]  str_mem[0:63];
    int          str_ptr = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- stream driver ----------------
    always @(negedge clk) hs_word = s_valid && s_ready;
    always @(posedge clk) begin
        #1;
        if (hs_word && word_q.size() != 0) begin
            void'(word_q.pop_front());
            n_words++;
        end
        s_valid = (word_q.size() != 0);
        s_data  = (word_q.size() != 0) ? word_q[0] : 32'd0;
    end

    // ---------------- datapath model: matched string shifter ----------------
    always @(negedge clk) hs_char = proc_match_char_next;
    always @(posedge clk) begin
        #1;
        if (hs_char) str_ptr++;
        proc_match_char = (str_ptr < 64) ? str_mem[str_ptr] : 8'd0;
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (proc_data_valid) begin
                n_strobes++;
                if (exp_byte_q.size() == 0) check("unexpected_byte", {120'd0, proc_data}, 128'hx0);
                else check("proc_data", {120'd0, proc_data}, {120'd0, exp_byte_q.pop_front()});
            end
            if (res_valid && res_ready) begin
                if (exp_res_q.size() == 0) check("unexpected_beat", {95'd0, res_last, res_data}, 128'hx0);
                else check("res_beat", {95'd0, res_last, res_data}, {95'd0, exp_res_q.pop_front()});
            end
            if (proc_match_char_next) n_char_next++;
            if (proc_start) n_start++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_string(input string s);
        for (int i = 0; i < 64; i++) str_mem[i] = (i < s.len()) ? s[i] : 8'd0;
    endtask

    task automatic push_word(input logic [31:0] w, input int nbytes);
        word_q.push_back(w);
        for (int i = 0; i < 4; i++)
            if (i < nbytes) exp_byte_q.push_back(w[8*i +: 8]);
    endtask

    task automatic issue_cmd(input logic [31:0] nb, input logic [15:0] len, input logic [127:0] h);
        @(posedge clk); #2;
        str_ptr         = 0;
        proc_match_char = str_mem[0];
        cmd_valid       = 1'b1;
        cmd_num_bytes   = nb;
        cmd_str_len     = len;
        cmd_target_hash = h;
        @(negedge clk);
        check("cmd_ready_idle", {127'd0, cmd_ready}, 128'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("cmd_ready_busy", {127'd0, cmd_ready}, 128'd0);
        check("busy", {127'd0, busy}, 128'd1);
    endtask

    task automatic wait_state(input state_t st, input string name);
        int k;
        k = 0;
        while (dbg_state != st && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) check(name, {124'd0, dbg_state}, {124'd0, st});
    endtask

    task automatic finish_done(input int delay);
        wait_state(S_WAIT_DONE, "reach_wait_done");
        repeat (delay) @(posedge clk);
        #1 proc_done = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!(dbg_state == S_IDLE && exp_res_q.size() == 0) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) check(name, {124'd0, dbg_state}, {124'd0, S_IDLE});
        @(posedge clk); #1;
        proc_done = 1'b0;
    endtask

    task automatic push_string_beats(input string s);
        logic [31:0] w;
        int n;
        n = s.len();
        for (int i = 0; i < n; i += 4) begin
            w = 32'd0;
            for (int j = 0; j < 4; j++)
                if (i + j < n) w[8*j +: 8] = s[i+j];
            exp_res_q.push_back({(i + 4 >= n), w});
        end
    endtask

    // ---------------- main sequence ----------------
    localparam logic [127:0] HASH_A = 128'h0123456789abcdef_fedcba9876543210;
    localparam string FOX = "The quick brown fox";

    initial begin
        int s0, c0, t0, w0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_num_bytes = '0; cmd_str_len = '0;
        cmd_target_hash = '0; s_valid = 1'b0; s_data = '0; proc_done = 1'b0;
        proc_match = 1'b0; proc_byte_pos = '0; proc_match_char = '0; res_ready = 1'b1;
        load_string("");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", {124'd0, dbg_state}, {124'd0, S_IDLE});
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_res_valid", {127'd0, res_valid}, 128'd0);
        check("rst_num_bytes", {96'd0, proc_num_bytes}, 128'd0);
        @(posedge clk); #1 reset = 1'b0;

        // 1 + 3: eight bytes, no match, done three cycles after the last byte
        s0 = n_strobes; c0 = n_char_next; t0 = n_start;
        proc_match = 1'b0; proc_byte_pos = 32'd0;
        push_word(32'h64636261, 4); push_word(32'h68676665, 4);
        exp_res_q.push_back({1'b1, 32'h0}); exp_res_q.push_back({1'b1, 32'h0});
        issue_cmd(32'd8, 16'd24, HASH_A);
        check("latched_num_bytes", {96'd0, proc_num_bytes}, 128'd8);
        check("latched_str_len", {112'd0, proc_str_len}, 128'd24);
        check("latched_hash", proc_target_hash, HASH_A);
        finish_done(3);
        wait_idle("t1_idle");
        check("t1_start_pulses", n_start - t0, 1);
        check("t1_strobes", n_strobes - s0, 8);
        check("t1_char_next", n_char_next - c0, 0);
        check("t1_bytes_left", exp_byte_q.size(), 0);

        // 2 + 3: six bytes, g/h dropped, a third word must stay unaccepted
        s0 = n_strobes; c0 = n_char_next; w0 = n_words;
        proc_byte_pos = 32'd6;
        push_word(32'h64636261, 4); push_word(32'h68676665, 2); word_q.push_back(32'hdeadbeef);
        exp_res_q.push_back({1'b1, 32'h0}); exp_res_q.push_back({1'b1, 32'h6});
        issue_cmd(32'd6, 16'd24, HASH_A);
        finish_done(3);
        wait_idle("t2_idle");
        check("t2_strobes", n_strobes - s0, 6);
        check("t2_words", n_words - w0, 2);
        check("t2_word_left", word_q.size(), 1);
        check("t2_char_next", n_char_next - c0, 0);
        word_q.delete();
        repeat (2) @(posedge clk);

        // 4: match at 0x1C, 19-char string read back
        c0 = n_char_next;
        load_string(FOX);
        proc_match = 1'b1; proc_byte_pos = 32'h1C;
        push_word(32'h64636261, 4);
        exp_res_q.push_back({1'b0, 32'h1}); exp_res_q.push_back({1'b0, 32'h1C});
        exp_res_q.push_back({1'b0, 32'h20656854}); exp_res_q.push_back({1'b0, 32'h63697571});
        exp_res_q.push_back({1'b0, 32'h7262206B}); exp_res_q.push_back({1'b0, 32'h206E776F});
        exp_res_q.push_back({1'b1, 32'h00786F66});
        issue_cmd(32'd4, 16'd152, HASH_A);
        finish_done(2);
        wait_idle("t4_idle");
        check("t4_char_next", n_char_next - c0, 19);

        // 5: backpressure on the first packed word
        c0 = n_char_next;
        push_word(32'h64636261, 4);
        exp_res_q.push_back({1'b0, 32'h1}); exp_res_q.push_back({1'b0, 32'h1C});
        push_string_beats(FOX);
        issue_cmd(32'd4, 16'd152, HASH_A);
        finish_done(1);
        wait_state(S_READ, "t5_reach_read");
        @(posedge clk); #1 res_ready = 1'b0;
        wait_state(S_EMIT, "t5_reach_emit");
        w0 = n_char_next;
        for (int i = 0; i < 5; i++) begin
            check("t5_stall_data", {96'd0, res_data}, {96'd0, 32'h20656854});
            check("t5_stall_valid", {127'd0, res_valid}, 128'd1);
            @(negedge clk);
        end
        check("t5_no_char_next_in_emit", n_char_next - w0, 0);
        @(posedge clk); #1 res_ready = 1'b1;
        wait_idle("t5_idle");
        check("t5_char_next", n_char_next - c0, 19);

        // 6: reset mid-FEED, then a zero-byte command
        proc_match = 1'b0;
        for (int i = 0; i < 4; i++) push_word(32'h11223344 + i, 4);
        issue_cmd(32'd16, 16'd8, HASH_A);
        s0 = n_strobes;
        for (int k = 0; k < 200 && (n_strobes - s0) < 3; k++) @(negedge clk);
        check("t6_feeding", {124'd0, dbg_state}, {124'd0, S_FEED});
        @(posedge clk); #1 reset = 1'b1;
        word_q.delete();
        @(posedge clk);
        @(negedge clk);
        exp_byte_q.delete();
        check("t6_rst_state", {124'd0, dbg_state}, {124'd0, S_IDLE});
        check("t6_rst_outputs", {123'd0, proc_start, proc_data_valid, s_ready, res_valid, busy}, 128'd0);
        check("t6_rst_data", {88'd0, proc_data, proc_num_bytes}, 128'd0);
        check("t6_rst_hash", proc_target_hash, 128'd0);
        check("t6_rst_cmd_ready", {127'd0, cmd_ready}, 128'd1);
        @(posedge clk); #1 reset = 1'b0;
        s0 = n_strobes; t0 = n_start;
        proc_match = 1'b1; proc_byte_pos = 32'd5;
        exp_res_q.push_back({1'b1, 32'h1}); exp_res_q.push_back({1'b1, 32'h5});
        issue_cmd(32'd0, 16'd0, 128'd0);
        finish_done(2);
        wait_idle("t6_idle");
        check("t6_start_pulses", n_start - t0, 1);
        check("t6_strobes", n_strobes - s0, 0);
        @(negedge clk);
        check("t6_cmd_ready_again", {127'd0, cmd_ready}, 128'd1);
        check("t6_res_valid_low", {127'd0, res_valid}, 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
